// File: rtl/fwd_scoreboard_if.sv
// Operand-forwarding scoreboard bus: EX-stage inputs in, per-source selects, stall and counters out.
interface fwd_scoreboard_if #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LAT_W     = 2,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
);
  logic                       hold_i;
  logic                       flush_i;
  logic                       ex_valid_i;
  logic [REG_AW-1:0]          ex_rd_i;
  logic                       ex_we_i;
  logic [LAT_W-1:0]           ex_lat_i;
  logic [NUM_SRC*REG_AW-1:0]  src_addr_i;
  logic [NUM_SRC-1:0]         src_used_i;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o;
  logic                       stall_o;
  logic [31:0]                stall_cnt_o;
  logic [31:0]                fwd_cnt_o;

  // Pipeline side: drives the EX-stage view, consumes selects and stall
  modport master (
    output hold_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_lat_i,
           src_addr_i, src_used_i,
    input  fwd_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );

  // Scoreboard side
  modport slave (
    input  hold_i, flush_i, ex_valid_i, ex_rd_i, ex_we_i, ex_lat_i,
           src_addr_i, src_used_i,
    output fwd_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers over FWD_DEPTH
// post-EX stages, picks the youngest producer per operand, and stalls on
// producers whose result is not yet forwardable.
module fwd_scoreboard #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LAT_W     = 2,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fwd_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [LAT_W-1:0]  cnt;
  } entry_t;

  entry_t                     r_ent [FWD_DEPTH];
  logic [31:0]                r_stall_cnt;
  logic [31:0]                r_fwd_cnt;

  entry_t                     w_new;
  entry_t                     w_shift [FWD_DEPTH];
  logic [NUM_SRC*SEL_W-1:0]   w_sel;
  logic [NUM_SRC-1:0]         w_hit;
  logic [NUM_SRC-1:0]         w_wait;
  logic                       w_stall;
  logic                       w_fire;
  logic                       w_any_fwd;
  logic [LAT_W-1:0]           w_lat_clamped;

  // Per-source youngest-producer search; only the youngest match decides stall
  always_comb begin
    w_sel  = '0;
    w_hit  = '0;
    w_wait = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        if (!w_hit[s] && bus.src_used_i[s] && r_ent[i].vld && r_ent[i].we &&
            (r_ent[i].rd != '0) &&
            (r_ent[i].rd == bus.src_addr_i[s*REG_AW +: REG_AW])) begin
          w_hit[s]                = 1'b1;
          w_sel[s*SEL_W +: SEL_W] = SEL_W'(i + 1);
          w_wait[s]               = (r_ent[i].cnt != '0);
        end
      end
    end
  end

  assign w_stall   = bus.ex_valid_i & (|w_wait);
  assign w_fire    = bus.ex_valid_i & ~w_stall & ~bus.hold_i & ~bus.flush_i;
  assign w_any_fwd = |w_sel;

  // Latency is clamped so an entry's countdown always reaches zero before it retires
  always_comb begin
    w_lat_clamped = bus.ex_lat_i;
    if (32'(bus.ex_lat_i) > FWD_DEPTH - 1) begin
      w_lat_clamped = LAT_W'(FWD_DEPTH - 1);
    end
  end

  // Next-entry image: new EX tag (or bubble) at stage 0, older stages shift with countdown
  always_comb begin
    w_new = '0;
    if (w_fire) begin
      w_new.vld = 1'b1;
      w_new.rd  = bus.ex_rd_i;
      w_new.we  = bus.ex_we_i;
      w_new.cnt = w_lat_clamped;
    end
    w_shift[0] = w_new;
    for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
      w_shift[i]     = r_ent[i-1];
      w_shift[i].cnt = (r_ent[i-1].cnt == '0) ? '0 : r_ent[i-1].cnt - 1'b1;
    end
  end

  // Scoreboard shift register; frozen while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (!bus.hold_i) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        r_ent[i] <= w_shift[i];
      end
    end
  end

  // Saturating stall and forward-activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!bus.hold_i) begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_any_fwd && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.fwd_sel_o   = w_sel;
  assign bus.stall_o     = w_stall;
  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.fwd_cnt_o   = r_fwd_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with hand-computed expectations.
module tb_fwd_scoreboard;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 3;
  localparam int unsigned D  = 2;
  localparam int unsigned LW = 2;
  localparam int unsigned SW = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fwd_scoreboard_if #(.REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .LAT_W(LW), .SEL_W(SW)) bus ();

  fwd_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .LAT_W(LW), .SEL_W(SW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] sel_of(input int s);
    return bus.fwd_sel_o[s*SW +: SW];
  endfunction

  task automatic ex_in(input logic v, input logic [AW-1:0] rd, input logic we, input logic [LW-1:0] lat);
    bus.ex_valid_i = v;
    bus.ex_rd_i    = rd;
    bus.ex_we_i    = we;
    bus.ex_lat_i   = lat;
  endtask

  task automatic src_in(input int s, input logic [AW-1:0] a, input logic u);
    bus.src_addr_i[s*AW +: AW] = a;
    bus.src_used_i[s]          = u;
  endtask

  task automatic idle();
    ex_in(1'b0, '0, 1'b0, '0);
    bus.src_addr_i = '0;
    bus.src_used_i = '0;
    bus.hold_i     = 1'b0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.fwd_sel_o !== '0) begin n_err++; $display("FAIL rst_sel: got %h want 0", bus.fwd_sel_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cnt_o); end
    n_cmp++; if (bus.fwd_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_fwd_cnt: got %0d want 0", bus.fwd_cnt_o); end
  endtask

  task automatic test_ex_forward();
    apply_reset();
    ex_in(1'b1, 5'd5, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd5, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL ex_sel_stage0: got %0d want 1", sel_of(0)); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL ex_stall: got %b want 0", bus.stall_o); end
    tick(); settle();
    n_cmp++; if (sel_of(0) !== 2'd2) begin n_err++; $display("FAIL ex_sel_stage1: got %0d want 2", sel_of(0)); end
    tick(); settle();
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL ex_sel_retired: got %0d want 0", sel_of(0)); end
    n_cmp++; if (bus.fwd_cnt_o !== 32'd2) begin n_err++; $display("FAIL ex_fwd_cnt: got %0d want 2", bus.fwd_cnt_o); end
    idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_in(1'b1, 5'd7, 1'b1, 2'd1); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(1, 5'd7, 1'b1); settle();
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", bus.stall_o); end
    n_cmp++; if (sel_of(1) !== 2'd1) begin n_err++; $display("FAIL lu_sel_wait: got %0d want 1", sel_of(1)); end
    tick(); settle();
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %b want 0", bus.stall_o); end
    n_cmp++; if (sel_of(1) !== 2'd2) begin n_err++; $display("FAIL lu_sel_ready: got %0d want 2", sel_of(1)); end
    tick(); idle(); settle();
    n_cmp++; if (bus.stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt_o); end
    n_cmp++; if (bus.fwd_cnt_o !== 32'd2) begin n_err++; $display("FAIL lu_fwd_cnt: got %0d want 2", bus.fwd_cnt_o); end
  endtask

  task automatic test_youngest();
    apply_reset();
    ex_in(1'b1, 5'd3, 1'b1, 2'd0); settle(); tick();
    settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd3, 1'b1); src_in(2, 5'd3, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL yw_sel0: got %0d want 1", sel_of(0)); end
    n_cmp++; if (sel_of(2) !== 2'd1) begin n_err++; $display("FAIL yw_sel2: got %0d want 1", sel_of(2)); end
    n_cmp++; if (sel_of(1) !== 2'd0) begin n_err++; $display("FAIL yw_sel1_unused: got %0d want 0", sel_of(1)); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL yw_stall: got %b want 0", bus.stall_o); end
    apply_reset();
    ex_in(1'b1, 5'd3, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd3, 1'b1, 2'd1); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd3, 1'b1); src_in(2, 5'd3, 1'b1); settle();
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL yw_nofallthru_stall: got %b want 1", bus.stall_o); end
    n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL yw_nofallthru_sel0: got %0d want 1", sel_of(0)); end
    n_cmp++; if (sel_of(2) !== 2'd1) begin n_err++; $display("FAIL yw_nofallthru_sel2: got %0d want 1", sel_of(2)); end
    idle();
  endtask

  task automatic test_x0_unused();
    apply_reset();
    ex_in(1'b1, 5'd0, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd0, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL x0_sel: got %0d want 0", sel_of(0)); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", bus.stall_o); end
    apply_reset();
    ex_in(1'b1, 5'd9, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd9, 1'b0); settle();
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL unused_sel: got %0d want 0", sel_of(0)); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL unused_stall: got %b want 0", bus.stall_o); end
    src_in(0, 5'd9, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL used_sel: got %0d want 1", sel_of(0)); end
    idle();
  endtask

  task automatic test_hold_flush();
    apply_reset();
    ex_in(1'b1, 5'd4, 1'b1, 2'd1); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd4, 1'b1); bus.hold_i = 1'b1; settle();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", k, bus.stall_o); end
      n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL hold_sel[%0d]: got %0d want 1", k, sel_of(0)); end
      tick();
    end
    bus.hold_i = 1'b0; settle();
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL hold_release_stall: got %b want 1", bus.stall_o); end
    n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL hold_cnt_frozen: got %0d want 0", bus.stall_cnt_o); end
    tick(); settle();
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL hold_after_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (sel_of(0) !== 2'd2) begin n_err++; $display("FAIL hold_after_sel: got %0d want 2", sel_of(0)); end
    n_cmp++; if (bus.stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL hold_after_cnt: got %0d want 1", bus.stall_cnt_o); end
    apply_reset();
    ex_in(1'b1, 5'd8, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd6, 1'b1, 2'd0); bus.flush_i = 1'b1; src_in(0, 5'd8, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd1) begin n_err++; $display("FAIL flush_keeps_older: got %0d want 1", sel_of(0)); end
    tick();
    bus.flush_i = 1'b0; ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd6, 1'b1); src_in(1, 5'd8, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL flush_no_entry: got %0d want 0", sel_of(0)); end
    n_cmp++; if (sel_of(1) !== 2'd2) begin n_err++; $display("FAIL flush_older_shift: got %0d want 2", sel_of(1)); end
    tick(); settle();
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL flush_no_entry_later: got %0d want 0", sel_of(0)); end
    idle();
  endtask

  task automatic test_lat_clamp();
    apply_reset();
    ex_in(1'b1, 5'd12, 1'b1, 2'd3); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(2, 5'd12, 1'b1); settle();
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL clamp_stall: got %b want 1", bus.stall_o); end
    tick(); settle();
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL clamp_ready_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (sel_of(2) !== 2'd2) begin n_err++; $display("FAIL clamp_ready_sel: got %0d want 2", sel_of(2)); end
    tick(); settle();
    n_cmp++; if (sel_of(2) !== 2'd0) begin n_err++; $display("FAIL clamp_retired: got %0d want 0", sel_of(2)); end
    idle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    ex_in(1'b1, 5'd10, 1'b1, 2'd0); settle(); tick();
    ex_in(1'b1, 5'd11, 1'b1, 2'd1); settle(); tick();
    ex_in(1'b1, 5'd0, 1'b0, 2'd0); src_in(0, 5'd10, 1'b1); src_in(1, 5'd11, 1'b1); settle();
    n_cmp++; if (sel_of(0) !== 2'd2) begin n_err++; $display("FAIL mid_sel0: got %0d want 2", sel_of(0)); end
    n_cmp++; if (sel_of(1) !== 2'd1) begin n_err++; $display("FAIL mid_sel1: got %0d want 1", sel_of(1)); end
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL mid_stall: got %b want 1", bus.stall_o); end
    tick(); settle();
    n_cmp++; if (sel_of(1) !== 2'd2) begin n_err++; $display("FAIL mid_sel1_ready: got %0d want 2", sel_of(1)); end
    n_cmp++; if (bus.stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL mid_stall_cnt: got %0d want 1", bus.stall_cnt_o); end
    n_cmp++; if (bus.fwd_cnt_o !== 32'd1) begin n_err++; $display("FAIL mid_fwd_cnt: got %0d want 1", bus.fwd_cnt_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_sel_o !== '0) begin n_err++; $display("FAIL mid_rst_sel: got %h want 0", bus.fwd_sel_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL mid_rst_stall_cnt: got %0d want 0", bus.stall_cnt_o); end
    n_cmp++; if (bus.fwd_cnt_o !== 32'd0) begin n_err++; $display("FAIL mid_rst_fwd_cnt: got %0d want 0", bus.fwd_cnt_o); end
    #1 rst = 1'b0;
    tick(); settle();
    n_cmp++; if (sel_of(1) !== 2'd0) begin n_err++; $display("FAIL mid_after_sel1: got %0d want 0", sel_of(1)); end
    n_cmp++; if (sel_of(0) !== 2'd0) begin n_err++; $display("FAIL mid_after_sel0: got %0d want 0", sel_of(0)); end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    idle();
    #3;
    test_reset();
    #9 rst = 1'b0;
    tick();
    test_ex_forward();
    test_load_use();
    test_youngest();
    test_x0_unused();
    test_hold_flush();
    test_lat_clamp();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
